// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a word over valid/ready and serialises it as
// start, LSB-first data, optional parity and stop bits, one bit per baud period.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state,      state_nxt;
    logic [CNT_W-1:0]     baud_cnt,   baud_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx,    bit_idx_nxt;
    logic [DATA_BITS-1:0] shift_reg,  shift_reg_nxt;
    logic                 parity_bit, parity_bit_nxt;
    logic                 tx_out_nxt;
    logic                 tx_ready_nxt;
    logic                 done_nxt;
    logic                 accept;
    logic                 bit_end;

    assign accept  = tx_valid && tx_ready;
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE);

    always_comb begin
        // NOTE: every *_nxt gets a default before the case so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_nxt      = state;
        baud_cnt_nxt   = baud_cnt;
        bit_idx_nxt    = bit_idx;
        shift_reg_nxt  = shift_reg;
        parity_bit_nxt = parity_bit;
        tx_out_nxt     = tx_out;
        tx_ready_nxt   = tx_ready;
        done_nxt       = 1'b0;

        if (state != IDLE) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_out_nxt = 1'b1;
                if (accept) begin
                    shift_reg_nxt  = tx_data;
                    parity_bit_nxt = (^tx_data) ^ (PARITY_ODD != 0);
                    tx_ready_nxt   = 1'b0;
                    tx_out_nxt     = 1'b0;
                    baud_cnt_nxt   = '0;
                    state_nxt      = START;
                end
            end

            START: begin
                if (bit_end) begin
                    bit_idx_nxt = '0;
                    tx_out_nxt  = shift_reg[0];
                    state_nxt   = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_reg_nxt = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_nxt = '0;
                        if (PARITY_EN != 0) begin
                            tx_out_nxt = parity_bit;
                            state_nxt  = PARITY;
                        end else begin
                            tx_out_nxt = 1'b1;
                            state_nxt  = STOP;
                        end
                    end else begin
                        // After the shift, the next bit on the line is today's bit 1.
                        bit_idx_nxt = bit_idx + 1'b1;
                        tx_out_nxt  = shift_reg[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    bit_idx_nxt = '0;
                    tx_out_nxt  = 1'b1;
                    state_nxt   = STOP;
                end
            end

            STOP: begin
                // bit_idx is reused to count stop bits.
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_nxt  = '0;
                        tx_ready_nxt = 1'b1;
                        done_nxt     = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end

            default: begin
                tx_out_nxt   = 1'b1;
                tx_ready_nxt = 1'b1;
                baud_cnt_nxt = '0;
                bit_idx_nxt  = '0;
                state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples the
        // pre-edge values computed above; the comb block uses blocking.
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            // NOTE: the datapath word and parity are cleared as well, so an aborted
            // frame leaves nothing behind for the next one.
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            tx_ready   <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_reg_nxt;
            parity_bit <= parity_bit_nxt;
            tx_out     <= tx_out_nxt;
            tx_ready   <= tx_ready_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances (8N1, even parity, odd parity, two stop bits)
// driven by a fixed vector table, directed corner sequences and random frames.
module tb_uart_tx_ctrl;

    localparam int CPB = 16;
    localparam int NI  = 4;
    localparam int PE_A   [NI] = '{0, 1, 1, 0};
    localparam int ODD_A  [NI] = '{0, 0, 1, 0};
    localparam int SB_A   [NI] = '{1, 1, 1, 2};

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [11:0] line;   // bit i = line level during bit period i
        int         nbits;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data_a  [NI];
    logic       tx_valid_a [NI];
    logic       rst_n_a    [NI];
    logic       tx_out_a   [NI];
    logic       tx_ready_a [NI];
    logic       busy_a     [NI];
    logic       done_a     [NI];

    int checks   = 0;
    int failures = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut0 (
        .clk(clk), .rst_n(rst_n_a[0]), .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]),
        .tx_ready(tx_ready_a[0]), .tx_out(tx_out_a[0]), .busy(busy_a[0]), .done(done_a[0]));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n_a[1]), .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]),
        .tx_ready(tx_ready_a[1]), .tx_out(tx_out_a[1]), .busy(busy_a[1]), .done(done_a[1]));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst_n(rst_n_a[2]), .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]),
        .tx_ready(tx_ready_a[2]), .tx_out(tx_out_a[2]), .busy(busy_a[2]), .done(done_a[2]));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n_a[3]), .tx_data(tx_data_a[3]), .tx_valid(tx_valid_a[3]),
        .tx_ready(tx_ready_a[3]), .tx_out(tx_out_a[3]), .busy(busy_a[3]), .done(done_a[3]));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {tx_out, tx_ready, busy, done}
    function automatic logic [3:0] flags(int k);
        return {tx_out_a[k], tx_ready_a[k], busy_a[k], done_a[k]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line levels of a whole frame, built from the framing rules.
    function automatic void model_line(int k, logic [7:0] d, output logic [11:0] line,
                                       output int nbits);
        logic q [$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (PE_A[k] != 0) q.push_back((($countones(d) % 2) == 1) != (ODD_A[k] != 0));
        for (int i = 0; i < SB_A[k]; i++) q.push_back(1'b1);
        line  = '0;
        nbits = q.size();
        foreach (q[i]) line[i] = q[i];
    endfunction

    // Presents d, steps through the acceptance edge, then checks every cycle of the
    // frame. stop_at >= 0 ends the check early (for aborts) without the done check.
    task automatic run_frame(int k, logic [7:0] d, logic [11:0] line, int nbits, bit hold,
                             int toggle_at, logic [7:0] toggle_val, int stop_at, string tag);
        int flen = nbits * CPB;
        int lim  = (stop_at >= 0) ? stop_at : flen;
        tx_data_a[k]  = d;
        tx_valid_a[k] = 1'b1;
        step();
        if (!hold) tx_valid_a[k] = 1'b0;
        for (int c = 0; c < lim; c++) begin
            if (c == toggle_at) tx_data_a[k] = toggle_val;
            check($sformatf("%s inst%0d c%0d", tag, k, c), flags(k), {line[c / CPB], 3'b010});
            step();
        end
        if (stop_at < 0) check($sformatf("%s inst%0d end", tag, k), flags(k), 4'b1101);
    endtask

    task automatic idle(int k, int n, string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s inst%0d idle%0d", tag, k, i), flags(k), 4'b1100);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [6];
        logic [11:0] l0, l1;
        int          n0, n1;

        tbl[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
        tbl[1] = '{1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
        tbl[2] = '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11};
        tbl[3] = '{1, 8'h03, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11};
        tbl[4] = '{3, 8'hFF, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11};
        tbl[5] = '{0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10};

        // Reset held with a word offered: nothing may start.
        for (int k = 0; k < NI; k++) begin
            rst_n_a[k]    = 1'b0;
            tx_valid_a[k] = 1'b1;
            tx_data_a[k]  = 8'h55;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            for (int k = 0; k < NI; k++) check($sformatf("reset inst%0d c%0d", k, c), flags(k), 4'b1100);
        end
        for (int k = 0; k < NI; k++) begin
            rst_n_a[k]    = 1'b1;
            tx_valid_a[k] = 1'b0;
        end
        step();
        for (int k = 0; k < NI; k++) check($sformatf("post_reset inst%0d", k), flags(k), 4'b1100);

        // Fixed vectors.
        foreach (tbl[i]) begin
            run_frame(tbl[i].inst, tbl[i].data, tbl[i].line, tbl[i].nbits, 1'b0, -1, 8'h00, -1,
                      $sformatf("vec%0d", i));
            idle(tbl[i].inst, 2, $sformatf("vec%0d", i));
        end

        // Back-to-back with tx_data changed mid-frame.
        model_line(0, 8'h00, l0, n0);
        model_line(0, 8'hFF, l1, n1);
        run_frame(0, 8'h00, l0, n0, 1'b1, 80, 8'hFF, -1, "b2b_first");
        run_frame(0, 8'hFF, l1, n1, 1'b0, -1, 8'h00, -1, "b2b_second");
        idle(0, 2, "b2b");

        // Reset pulse at cycle 50 of a frame, then a normal frame.
        model_line(0, 8'hA5, l0, n0);
        run_frame(0, 8'hA5, l0, n0, 1'b0, -1, 8'h00, 50, "abort");
        rst_n_a[0] = 1'b0;
        step();
        check("abort reset edge", flags(0), 4'b1100);
        rst_n_a[0] = 1'b1;
        idle(0, 4, "abort");
        model_line(0, 8'h3C, l0, n0);
        run_frame(0, 8'h3C, l0, n0, 1'b0, -1, 8'h00, -1, "after_abort");
        idle(0, 1, "after_abort");

        // Random frames against the model, mixing gaps and back-to-back.
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 6; j++) begin
                logic [7:0] d;
                bit         hold;
                d    = 8'($urandom);
                hold = (j < 5) && ($urandom_range(0, 1) == 1);
                model_line(k, d, l0, n0);
                run_frame(k, d, l0, n0, hold, int'($urandom_range(0, n0 * CPB - 1)),
                          8'($urandom), -1, "rand");
                if (!hold) idle(k, int'($urandom_range(1, 3)), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side controller for the UART transmitter.
- Accepts a parallel word over a valid/ready handshake and captures it into an internal shift register.
- Sequences start, data (LSB first), optional parity and stop bits onto the serial line, one bit per baud period.
- Owns the baud-period counter and bit counter. The registered serial output drives the line directly.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Legal range ≥2.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- tx_data  in  DATA_BITS  word to send; sampled only at acceptance
- tx_valid  in  1  requester has a word on tx_data
- tx_ready  out  1  controller can accept a word (registered)
- tx_out  out  1  serial line; idle high (registered)
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, tx_out=1, tx_ready=1, busy=0, done=0.
  - Baud counter, bit counter and shift register cleared.
  - Reset overrides everything, including tx_valid.
- Acceptance: occurs at a rising edge where tx_valid=1 and tx_ready=1 and rst_n=1. On that edge:
  - shift register <= tx_data, and the parity bit is computed from tx_data: XOR of all bits, inverted if PARITY_ODD.
  - tx_ready <= 0, busy <= 1, tx_out <= 0, state <= START, baud counter <= 0.
- States:
  - IDLE: tx_out=1. Wait for acceptance.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_out=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx_out=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE. On that edge tx_ready<=1, busy<=0, done<=1 for exactly one cycle.
- Bit timing:
  - Baud counter counts 0..CLKS_PER_BIT-1.
  - A bit ends at the edge where count == CLKS_PER_BIT-1; the counter wraps to 0 on that edge.
  - tx_out changes only on bit boundaries, so it is glitch-free.
- Latency: the first start-bit cycle is the cycle immediately after the acceptance edge.
- Frame length: F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the acceptance edge to the edge where tx_ready reasserts.
- Back-to-back frames: with tx_valid held high, the next word is accepted on the edge after tx_ready reasserts. This gives a minimum inter-frame idle-high gap of exactly 1 cycle beyond the stop bits.
- While busy:
  - tx_valid and tx_data are ignored; no queueing.
  - A word presented while tx_ready=0 is neither lost nor captured. The requester holds it until acceptance.
- Reset mid-frame: on the reset edge, tx_out returns to 1 and the frame is aborted with no done pulse. The next frame after reset is sent normally.
- Counter widths: baud counter is clog2(CLKS_PER_BIT); bit index is clog2(DATA_BITS+1). No overflow is possible within legal parameters.

Test Plan:
- Reset check: rst_n=0 for 3 cycles with tx_valid=1 and tx_data=8'h55.
  - Required: tx_out=1, tx_ready=1, busy=0, done=0 throughout; no frame starts.
- Single frame, 8'hA5, defaults:
  - tx_out=0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles.
  - done pulses and tx_ready=1 at cycle 160 after the acceptance edge.
- Parity, PARITY_EN=1:
  - 8'h07 even: parity bit 1. 8'h07 odd: parity bit 0. 8'h03 even: parity bit 0.
  - Frame length 176 cycles.
- Back-to-back, tx_valid held high with 8'h00 then 8'hFF; tx_data toggled mid-frame:
  - First frame is unaffected by the toggle.
  - Exactly 1 extra idle-high cycle between frames.
  - Second frame is all ones after its start bit.
- Reset mid-frame: pull rst_n low at cycle 50 of a frame for 1 cycle.
  - tx_out=1 and tx_ready=1 from the next cycle; no done pulse.
  - A following 8'h3C frame transmits correctly.
- STOP_BITS=2, 8'hFF:
  - Stop period is high for 32 cycles; done at cycle 176.
  - busy=1 for exactly 176 cycles.
